// File: rtl/dmem_mmio_if.sv
// -----------------------------------------------------------------------------
// dmem_mmio_if
// Data-port bus between the 8-bit core and the data memory / MMIO block.
//   memwrite  : write strobe from the core
//   addr      : byte address (core aluout)
//   writedata : store data
//   readdata  : load data, combinational from addr
// Modports: master (core side), slave (memory side).
// -----------------------------------------------------------------------------
interface dmem_mmio_if #(
  parameter int DWIDTH = 8
);
  logic              memwrite;
  logic [DWIDTH-1:0] addr;
  logic [DWIDTH-1:0] writedata;
  logic [DWIDTH-1:0] readdata;

  modport master (
    output memwrite,
    output addr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  addr,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/dmem_mmio.sv
// -----------------------------------------------------------------------------
// dmem_mmio
// Data-side memory for the 8-bit single-cycle CPU: 240-byte RAM, GPIO block
// and an optional down-counting timer with a sticky interrupt flag.
//
// Ports:
//   clk        : system clock, all state updates on the rising edge
//   reset      : synchronous, active-high; beats any same-cycle write
//   bus        : dmem_mmio_if.slave (memwrite, addr, writedata, readdata)
//   gpio_in    : asynchronous inputs, 2-flop synchronized
//   gpio_out   : registered output port
//   timer_irq  : timer FLAG
//
// Memory map: 0x00-0xEF RAM, 0xF0 GPIO_OUT, 0xF1 GPIO_IN, 0xF2 TIMER_CTRL
// ({FLAG,00000,AUTO,EN}), 0xF3 TIMER_LOAD, 0xF4 TIMER_COUNT, rest reads 0.
//
// Build option: define DMEM_TIMER_EN to include the timer. Without it
// 0xF2-0xF4 read 0, ignore writes, and timer_irq is tied low.
// -----------------------------------------------------------------------------
module dmem_mmio #(
  parameter int DWIDTH   = 8,
  parameter int PRESCALE = 4
) (
  input  logic       clk,
  input  logic       reset,
  dmem_mmio_if.slave bus,
  input  logic [7:0] gpio_in,
  output logic [7:0] gpio_out,
  output logic       timer_irq
);

  localparam logic [7:0] ADDR_GPIO_OUT = 8'hF0;
  localparam logic [7:0] ADDR_GPIO_IN  = 8'hF1;
  localparam logic [7:0] ADDR_CTRL     = 8'hF2;
  localparam logic [7:0] ADDR_LOAD     = 8'hF3;
  localparam logic [7:0] ADDR_COUNT    = 8'hF4;

  logic [7:0] addr8;
  logic [7:0] wdata8;
  logic [7:0] rdata;

  assign addr8  = bus.addr[7:0];
  assign wdata8 = bus.writedata[7:0];

  // ---------------------------------------------------------------- RAM
  // Combinational read, so a small distributed array rather than block RAM.
  logic [7:0] ram [0:239];
  logic       wr_ram;

  assign wr_ram = bus.memwrite && (addr8 < ADDR_GPIO_OUT);

  always_ff @(posedge clk) begin
    if (!reset && wr_ram) begin
      ram[addr8] <= wdata8;
    end
  end

  // ---------------------------------------------------------------- GPIO
  logic [7:0] gpio_out_q;
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      gpio_out_q <= 8'h00;
      sync1_q    <= 8'h00;
      sync2_q    <= 8'h00;
    end else begin
      sync1_q <= gpio_in;
      sync2_q <= sync1_q;
      if (bus.memwrite && addr8 == ADDR_GPIO_OUT) begin
        gpio_out_q <= wdata8;
      end
    end
  end

  assign gpio_out = gpio_out_q;

`ifdef DMEM_TIMER_EN
  // ---------------------------------------------------------------- Timer
  localparam logic [7:0] PRESC_MAX = 8'(PRESCALE - 1);

  logic       en_q, en_d;
  logic       auto_q, auto_d;
  logic       flag_q, flag_d;
  logic [7:0] load_q, load_d;
  logic [7:0] count_q, count_d;
  logic [7:0] presc_q, presc_d;
  logic       tick;
  logic       flag_set;
  logic       wr_ctrl;
  logic       wr_load;
  logic [4:0] unused_ctrl_bits;

  assign tick             = en_q && (presc_q == PRESC_MAX);
  assign flag_set         = tick && (count_q == 8'h00);
  assign wr_ctrl          = bus.memwrite && addr8 == ADDR_CTRL;
  assign wr_load          = bus.memwrite && addr8 == ADDR_LOAD;
  assign unused_ctrl_bits = wdata8[6:2];

  // Timer events first, then register writes override them so that the
  // written values win every same-cycle collision. The flag set is applied
  // last so it beats a W1C in the same cycle.
  always_comb begin
    en_d    = en_q;
    auto_d  = auto_q;
    flag_d  = flag_q;
    load_d  = load_q;
    count_d = count_q;
    presc_d = presc_q;

    if (en_q) begin
      presc_d = tick ? 8'h00 : presc_q + 8'h01;
    end

    if (tick) begin
      if (count_q != 8'h00) begin
        count_d = count_q - 8'h01;
      end else if (auto_q) begin
        count_d = load_q;
      end else begin
        en_d = 1'b0;
      end
    end

    if (wr_ctrl) begin
      en_d   = wdata8[0];
      auto_d = wdata8[1];
      // Only a 0->1 enable restarts the prescaler; rewriting EN=1 does not.
      if (wdata8[0] && !en_q) begin
        presc_d = 8'h00;
      end
      if (wdata8[7]) begin
        flag_d = 1'b0;
      end
    end

    if (wr_load) begin
      load_d  = wdata8;
      count_d = wdata8;
      presc_d = 8'h00;
    end

    if (flag_set) begin
      flag_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      en_q    <= 1'b0;
      auto_q  <= 1'b0;
      flag_q  <= 1'b0;
      load_q  <= 8'h00;
      count_q <= 8'h00;
      presc_q <= 8'h00;
    end else begin
      en_q    <= en_d;
      auto_q  <= auto_d;
      flag_q  <= flag_d;
      load_q  <= load_d;
      count_q <= count_d;
      presc_q <= presc_d;
    end
  end

  assign timer_irq = flag_q;
`else
  assign timer_irq = 1'b0;
`endif

  // ---------------------------------------------------------------- Read mux
  always_comb begin
    rdata = 8'h00;
    if (addr8 < ADDR_GPIO_OUT) begin
      rdata = ram[addr8];
    end else begin
      case (addr8)
        ADDR_GPIO_OUT: rdata = gpio_out_q;
        ADDR_GPIO_IN:  rdata = sync2_q;
`ifdef DMEM_TIMER_EN
        ADDR_CTRL:     rdata = {flag_q, 5'b00000, auto_q, en_q};
        ADDR_LOAD:     rdata = load_q;
        ADDR_COUNT:    rdata = count_q;
`endif
        default:       rdata = 8'h00;
      endcase
    end
  end

  assign bus.readdata = DWIDTH'(rdata);

endmodule
